// File: rtl/ram16k_stream_port.sv
// Stream sequencer in front of RAM16K: LOAD writes a valid/ready word stream to
// consecutive addresses, DUMP reads a consecutive address range back out as a stream.
module ram16k_stream_port #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DUMP_RD,
    DUMP_CAP,
    DUMP_HOLD,
    DONE
  } state_t;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  addr, addr_d;
  logic [LEN_W-1:0]   remaining, remaining_d;
  logic [DATA_W-1:0]  m_data_d;
  logic               m_valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
    end else begin
      state     <= state_d;
      addr      <= addr_d;
      remaining <= remaining_d;
      m_data    <= m_data_d;
      m_valid   <= m_valid_d;
    end
  end

  always_comb begin
    state_d     = state;
    addr_d      = addr;
    remaining_d = remaining;
    m_data_d    = m_data;
    m_valid_d   = m_valid;
    case (state)
      IDLE: begin
        if (cmd_start) begin
          addr_d      = cmd_base;
          remaining_d = cmd_len;
          if (cmd_len == '0)
            state_d = DONE;
          else if (cmd_mode)
            state_d = DUMP_RD;
          else
            state_d = LOAD;
        end
      end
      LOAD: begin
        if (s_valid) begin
          addr_d      = addr + ADDR_W'(1);
          remaining_d = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1))
            state_d = DONE;
        end
      end
      DUMP_RD: state_d = DUMP_CAP;
      // One full cycle of stable address before capture covers registered-read RAMs too.
      DUMP_CAP: begin
        m_data_d  = ram_out;
        m_valid_d = 1'b1;
        state_d   = DUMP_HOLD;
      end
      DUMP_HOLD: begin
        if (m_valid && m_ready) begin
          m_valid_d   = 1'b0;
          addr_d      = addr + ADDR_W'(1);
          remaining_d = remaining - LEN_W'(1);
          state_d     = (remaining == LEN_W'(1)) ? DONE : DUMP_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst_n lets a reset mid-transfer suppress the write in that same cycle.
  assign s_ready     = rst_n && (state == LOAD);
  assign ram_load    = s_valid && s_ready;
  assign ram_address = addr;
  assign ram_in      = s_data;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_ram16k_stream_port.sv
// Directed bench for ram16k_stream_port with a combinational-read RAM16K model.
module tb_ram16k_stream_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start, cmd_mode;
  logic [13:0] cmd_base;
  logic [14:0] cmd_len;
  logic        busy, done;
  logic [15:0] s_data;
  logic        s_valid, s_ready;
  logic [15:0] m_data;
  logic        m_valid, m_ready;
  logic [13:0] ram_address;
  logic [15:0] ram_in, ram_out;
  logic        ram_load;

  logic [15:0] mem [0:16383];

  int checkCount = 0;
  int passCount  = 0;

  typedef struct packed {
    logic            mode;
    logic [13:0]     base;
    logic [14:0]     len;
    logic [3:0][15:0] words;
    logic [15:0]     gaps;
    logic [3:0]      stall;
    logic            intrude;
  } vec_t;

  vec_t vecs [6];

  ram16k_stream_port dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic startCmd(input logic mode, input logic [13:0] base, input logic [14:0] len);
    @(negedge clk);
    cmd_mode = mode; cmd_base = base; cmd_len = len; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic runLoad(input vec_t v);
    int idx = 0;
    int c = 0;
    startCmd(1'b0, v.base, v.len);
    while (idx < int'(v.len) && c < 16) begin
      if (v.intrude) begin
        cmd_start = (c == 0); cmd_mode = 1'b1; cmd_base = 14'd200; cmd_len = 15'd0;
      end
      s_valid = !v.gaps[c];
      s_data  = v.words[idx];
      #1;
      checkOutput("load s_ready", {15'd0, s_ready}, 16'd1);
      checkOutput("load ram_load", {15'd0, ram_load}, {15'd0, s_valid});
      if (s_valid) begin
        checkOutput("load address", {2'b0, ram_address}, {2'b0, v.base + 14'(idx)});
        idx++;
      end
      @(negedge clk);
      c++;
    end
    cmd_start = 1'b0;
    s_valid = 1'b0;
    checkOutput("load word count", 16'(idx), 16'(v.len));
    #1;
    checkOutput("load done pulse", {15'd0, done}, 16'd1);
    @(negedge clk);
    checkOutput("load done width", {15'd0, done}, 16'd0);
    checkOutput("load busy after", {15'd0, busy}, 16'd0);
  endtask

  task automatic runDump(input vec_t v);
    int n;
    logic [15:0] held;
    startCmd(1'b1, v.base, v.len);
    for (int i = 0; i < int'(v.len); i++) begin
      n = 0;
      while (!m_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      checkOutput("dump m_valid latency", 16'(n), 16'd2);
      checkOutput("dump ram_load", {15'd0, ram_load}, 16'd0);
      checkOutput("dump m_data", m_data, v.words[i]);
      held = m_data;
      for (int s = 0; s < int'(v.stall); s++) begin
        @(negedge clk);
        checkOutput("stall m_valid", {15'd0, m_valid}, 16'd1);
        checkOutput("stall m_data", m_data, held);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      if (i < int'(v.len) - 1)
        checkOutput("dump m_valid drop", {15'd0, m_valid}, 16'd0);
    end
    checkOutput("dump done pulse", {15'd0, done}, 16'd1);
    @(negedge clk);
    checkOutput("dump done width", {15'd0, done}, 16'd0);
    checkOutput("dump busy after", {15'd0, busy}, 16'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.mode) runDump(v);
    else runLoad(v);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{1'b0, 14'd0,     15'd4, {16'h5A5D, 16'h5A5C, 16'h5A5B, 16'h5A5A}, 16'h0000, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 14'd0,     15'd4, {16'h5A5D, 16'h5A5C, 16'h5A5B, 16'h5A5A}, 16'h0000, 4'd0, 1'b0};
    vecs[2] = '{1'b0, 14'd16382, 15'd4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 16'h0000, 4'd0, 1'b0};
    vecs[3] = '{1'b1, 14'd16382, 15'd4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 16'h0000, 4'd0, 1'b0};
    vecs[4] = '{1'b0, 14'd40,    15'd4, {16'hBEE3, 16'hBEE2, 16'hBEE1, 16'hBEE0}, 16'h0052, 4'd0, 1'b0};
    vecs[5] = '{1'b1, 14'd40,    15'd4, {16'hBEE3, 16'hBEE2, 16'hBEE1, 16'hBEE0}, 16'h0000, 4'd3, 1'b0};

    rst_n = 1'b0; cmd_start = 1'b0; cmd_mode = 1'b0; cmd_base = '0; cmd_len = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset s_ready", {15'd0, s_ready}, 16'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset busy", {15'd0, busy}, 16'd0);
    checkOutput("reset done", {15'd0, done}, 16'd0);
    checkOutput("reset m_valid", {15'd0, m_valid}, 16'd0);
    checkOutput("reset m_data", m_data, 16'h0000);
    checkOutput("reset ram_address", {2'b0, ram_address}, 16'd0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Zero-length command: done next cycle and no write even with s_valid high.
    startCmd(1'b0, 14'd7, 15'd0);
    s_valid = 1'b1;
    #1;
    checkOutput("len0 done", {15'd0, done}, 16'd1);
    checkOutput("len0 ram_load", {15'd0, ram_load}, 16'd0);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("len0 busy after", {15'd0, busy}, 16'd0);

    // cmd_start while busy must not disturb the running LOAD.
    v = '{1'b0, 14'd100, 15'd2, {16'h0, 16'h0, 16'hCAF1, 16'hCAF0}, 16'h0001, 4'd0, 1'b1};
    runLoad(v);
    v.mode = 1'b1; v.intrude = 1'b0; v.gaps = '0;
    runDump(v);

    // Reset after two of four LOAD words.
    v = '{1'b0, 14'd50, 15'd4, {16'hC003, 16'hC002, 16'hC001, 16'hC000}, 16'h0000, 4'd0, 1'b0};
    runLoad(v);
    startCmd(1'b0, 14'd50, 15'd4);
    s_valid = 1'b1; s_data = 16'hD000;
    @(negedge clk);
    s_data = 16'hD001;
    @(negedge clk);
    s_data = 16'hD002; rst_n = 1'b0;
    #1;
    checkOutput("abort ram_load", {15'd0, ram_load}, 16'd0);
    checkOutput("abort s_ready", {15'd0, s_ready}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; s_valid = 1'b0;
    #1;
    checkOutput("abort busy", {15'd0, busy}, 16'd0);
    checkOutput("abort done", {15'd0, done}, 16'd0);
    v = '{1'b1, 14'd50, 15'd4, {16'hC003, 16'hC002, 16'hD001, 16'hD000}, 16'h0000, 4'd0, 1'b0};
    runDump(v);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
